// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the RAM1 port arbiter:
// FSM state encoding, requester indices and default timeout.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    localparam int DEFAULT_MFC_TIMEOUT = 15;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: combinational winner,
// registered pointer remembering who was served last.
module rr_arbiter_2
    import memory_arbiter_pkg::*;
(
    input  logic       clk_27,
    input  logic       Reset,
    input  logic [1:0] Req,
    input  logic       update,
    output logic [1:0] winner
);

    // High when the debug requester won the most recent grant.
    // Resets high so the processor wins the first tie.
    logic last_dbg;

    // Pick the requester that was not served last on a tie.
    always_comb begin
        winner = Req;
        if (Req == 2'b11) begin
            winner = last_dbg ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner whenever a grant is actually issued.
    always_ff @(posedge clk_27) begin
        if (Reset) begin
            last_dbg <= 1'b1;
        end else if (update) begin
            last_dbg <= winner[REQ_DBG];
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the RAM1 port between the processor and the debug viewer.
// Round-robin grant, MFC handshake with timeout, one-cycle Done pulse.
module ram_port_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MFC_TIMEOUT = DEFAULT_MFC_TIMEOUT
) (
    input  logic              clk_27,
    input  logic              Reset,
    input  logic [1:0]        Req,
    input  logic [1:0]        Read_H_Write_L,
    input  logic [ADDR_W-1:0] Address0,
    input  logic [ADDR_W-1:0] Address1,
    input  logic [DATA_W-1:0] Data_In0,
    input  logic [DATA_W-1:0] Data_In1,
    output logic [DATA_W-1:0] Data_Out,
    output logic [1:0]        Done,
    output logic [1:0]        Error,
    output logic [1:0]        Grant,
    output logic [ADDR_W-1:0] RAM1_Address,
    output logic              RAM1_Read_H_Write_L,
    output logic              RAM1_Out_Enable,
    output logic [DATA_W-1:0] RAM1_Data_In,
    input  logic [DATA_W-1:0] RAM1_Data_Out,
    input  logic              RAM1_MFC
);

    localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       winner;
    logic             start;
    logic             pick_dbg;

    // A stale MFC from the previous access holds off the next grant.
    assign start    = (state == ST_IDLE) && (|Req) && !RAM1_MFC;
    assign pick_dbg = winner[REQ_DBG];

    rr_arbiter_2 u_rr (
        .clk_27 (clk_27),
        .Reset  (Reset),
        .Req    (Req),
        .update (start),
        .winner (winner)
    );

    // Grant / access / completion sequencer with registered outputs.
    always_ff @(posedge clk_27) begin
        if (Reset) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            Grant               <= 2'b00;
            Done                <= 2'b00;
            Error               <= 2'b00;
            Data_Out            <= '0;
            RAM1_Address        <= '0;
            RAM1_Data_In        <= '0;
            RAM1_Read_H_Write_L <= 1'b1;
            RAM1_Out_Enable     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    Done  <= 2'b00;
                    Error <= 2'b00;
                    if (start) begin
                        state           <= ST_ACCESS;
                        cnt             <= '0;
                        Grant           <= winner;
                        RAM1_Out_Enable <= 1'b1;
                        RAM1_Address    <= pick_dbg ? Address1 : Address0;
                        RAM1_Data_In    <= pick_dbg ? Data_In1 : Data_In0;
                        RAM1_Read_H_Write_L <= pick_dbg
                            ? Read_H_Write_L[REQ_DBG]
                            : Read_H_Write_L[REQ_CPU];
                    end
                end
                ST_ACCESS: begin
                    if (RAM1_MFC) begin
                        state           <= ST_DONE;
                        Done            <= Grant;
                        Error           <= 2'b00;
                        Grant           <= 2'b00;
                        RAM1_Out_Enable <= 1'b0;
                        if (RAM1_Read_H_Write_L) begin
                            Data_Out <= RAM1_Data_Out;
                        end
                    end else if (cnt == CNT_W'(MFC_TIMEOUT)) begin
                        state           <= ST_DONE;
                        Done            <= Grant;
                        Error           <= Grant;
                        Grant           <= 2'b00;
                        RAM1_Out_Enable <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    Done  <= 2'b00;
                    Error <= 2'b00;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised bench for ram_port_arbiter with a transaction-level
// model of round-robin order, MFC/timeout latency and read data.
module tb_ram_port_arbiter;

    localparam int TMO = 15;

    logic        clk_27 = 1'b0;
    logic        Reset;
    logic [1:0]  Req;
    logic [1:0]  Read_H_Write_L;
    logic [31:0] Address0, Address1;
    logic [31:0] Data_In0, Data_In1;
    logic [31:0] Data_Out;
    logic [1:0]  Done, Error, Grant;
    logic [31:0] RAM1_Address;
    logic        RAM1_Read_H_Write_L;
    logic        RAM1_Out_Enable;
    logic [31:0] RAM1_Data_In;
    logic [31:0] RAM1_Data_Out;
    logic        RAM1_MFC;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int          last_srv;
    int          exp_idx;
    logic        exp_dir;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_dout;
    bit          hold_req;

    always #5 clk_27 = ~clk_27;

    ram_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MFC_TIMEOUT (TMO)
    ) dut (
        .clk_27              (clk_27),
        .Reset               (Reset),
        .Req                 (Req),
        .Read_H_Write_L      (Read_H_Write_L),
        .Address0            (Address0),
        .Address1            (Address1),
        .Data_In0            (Data_In0),
        .Data_In1            (Data_In1),
        .Data_Out            (Data_Out),
        .Done                (Done),
        .Error               (Error),
        .Grant               (Grant),
        .RAM1_Address        (RAM1_Address),
        .RAM1_Read_H_Write_L (RAM1_Read_H_Write_L),
        .RAM1_Out_Enable     (RAM1_Out_Enable),
        .RAM1_Data_In        (RAM1_Data_In),
        .RAM1_Data_Out       (RAM1_Data_Out),
        .RAM1_MFC            (RAM1_MFC)
    );

    function automatic logic [1:0] onehot(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    // Present a request at a negedge and check the grant one edge later.
    task automatic start_txn(input logic [1:0] req, input logic [1:0] dir,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input bit hold);
        hold_req       = hold;
        Req            = req;
        Read_H_Write_L = dir;
        Address0       = a0;
        Address1       = a1;
        Data_In0       = w0;
        Data_In1       = w1;
        RAM1_MFC       = 1'b0;
        if (req == 2'b11) exp_idx = (last_srv == 1) ? 0 : 1;
        else              exp_idx = req[1] ? 1 : 0;
        last_srv  = exp_idx;
        exp_addr  = (exp_idx == 1) ? a1 : a0;
        exp_wdata = (exp_idx == 1) ? w1 : w0;
        exp_dir   = dir[exp_idx];
        @(negedge clk_27);
        n_cmp++;
        if (Grant !== onehot(exp_idx) || RAM1_Out_Enable !== 1'b1) begin
            n_bad++;
            $display("FAIL grant: got %b oe=%b, want %b oe=1",
                     Grant, RAM1_Out_Enable, onehot(exp_idx));
        end
        n_cmp++;
        if (RAM1_Address !== exp_addr || RAM1_Data_In !== exp_wdata ||
            RAM1_Read_H_Write_L !== exp_dir) begin
            n_bad++;
            $display("FAIL bus: got a=%h d=%h rw=%b, want a=%h d=%h rw=%b",
                     RAM1_Address, RAM1_Data_In, RAM1_Read_H_Write_L,
                     exp_addr, exp_wdata, exp_dir);
        end
    endtask

    // Memory model: MFC pulses d negedges after grant (never if d > TMO).
    task automatic finish_txn(input int d, input logic [31:0] mem);
        int  n;
        int  exp_n;
        bit  seen;
        bit  exp_err;
        exp_err = (d > TMO);
        exp_n   = (exp_err ? TMO : d) + 1;
        n       = 0;
        seen    = 0;
        while (!seen && n < 40) begin
            RAM1_MFC      = (n == d);
            RAM1_Data_Out = (n == d) ? mem : $urandom;
            if (!hold_req) begin
                Req            = 2'($urandom);
                Read_H_Write_L = 2'($urandom);
                Address0       = $urandom;
                Address1       = $urandom;
                Data_In0       = $urandom;
                Data_In1       = $urandom;
            end
            @(negedge clk_27);
            n++;
            if (Done !== 2'b00) seen = 1;
        end
        RAM1_MFC = 1'b0;
        if (!hold_req) Req = 2'b00;
        n_cmp++;
        if (!seen || n != exp_n) begin
            n_bad++;
            $display("FAIL latency: got %0d edges (seen=%0d), want %0d",
                     n, seen, exp_n);
        end
        n_cmp++;
        if (Done !== onehot(exp_idx) ||
            Error !== (exp_err ? onehot(exp_idx) : 2'b00)) begin
            n_bad++;
            $display("FAIL done: got done=%b err=%b, want done=%b err=%b",
                     Done, Error, onehot(exp_idx),
                     exp_err ? onehot(exp_idx) : 2'b00);
        end
        n_cmp++;
        if (Grant !== 2'b00 || RAM1_Out_Enable !== 1'b0 ||
            RAM1_Address !== exp_addr) begin
            n_bad++;
            $display("FAIL done_bus: got g=%b oe=%b a=%h, want g=00 oe=0 a=%h",
                     Grant, RAM1_Out_Enable, RAM1_Address, exp_addr);
        end
        if (!exp_err && exp_dir) exp_dout = mem;
        n_cmp++;
        if (Data_Out !== exp_dout) begin
            n_bad++;
            $display("FAIL data_out: got %h, want %h", Data_Out, exp_dout);
        end
        @(negedge clk_27);
        n_cmp++;
        if (Done !== 2'b00 || Error !== 2'b00 || RAM1_Out_Enable !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse: got done=%b err=%b oe=%b, want 00 00 0",
                     Done, Error, RAM1_Out_Enable);
        end
    endtask

    task automatic test_reset();
        Reset          = 1'b1;
        Req            = 2'b00;
        Read_H_Write_L = 2'b11;
        Address0       = '0;
        Address1       = '0;
        Data_In0       = '0;
        Data_In1       = '0;
        RAM1_Data_Out  = '0;
        RAM1_MFC       = 1'b0;
        last_srv       = 1;
        exp_dout       = '0;
        hold_req       = 0;
        repeat (2) @(negedge clk_27);
        n_cmp++;
        if (Grant !== 2'b00 || Done !== 2'b00 || Error !== 2'b00 ||
            RAM1_Out_Enable !== 1'b0 || Data_Out !== 32'h0 ||
            RAM1_Address !== 32'h0 || RAM1_Data_In !== 32'h0 ||
            RAM1_Read_H_Write_L !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: got g=%b d=%b e=%b oe=%b do=%h a=%h di=%h rw=%b, want zeros rw=1",
                     Grant, Done, Error, RAM1_Out_Enable, Data_Out,
                     RAM1_Address, RAM1_Data_In, RAM1_Read_H_Write_L);
        end
        Reset = 1'b0;
        @(negedge clk_27);
    endtask

    task automatic test_single_read();
        start_txn(2'b01, 2'b11, 32'h10, 32'h99, 32'h1, 32'h2, 0);
        finish_txn(2, 32'hDEADBEEF);
    endtask

    task automatic test_write();
        start_txn(2'b10, 2'b01, 32'h77, 32'h4, 32'h5, 32'h12345678, 0);
        finish_txn(1, 32'hCAFEF00D);
    endtask

    task automatic test_contention();
        test_reset();
        for (int i = 0; i < 4; i++) begin
            start_txn(2'b11, 2'b11, 32'h100 + i, 32'h200 + i,
                      32'h0, 32'h0, 1);
            n_cmp++;
            if (exp_idx != (i % 2)) begin
                n_bad++;
                $display("FAIL rr_order: access %0d model %0d, want %0d",
                         i, exp_idx, i % 2);
            end
            finish_txn(i, 32'hA000_0000 + i);
        end
        Req = 2'b00;
        @(negedge clk_27);
    endtask

    task automatic test_timeout();
        start_txn(2'b01, 2'b11, 32'h20, 32'h0, 32'h0, 32'h0, 0);
        finish_txn(99, 32'hBAD0BAD0);
        start_txn(2'b01, 2'b11, 32'h24, 32'h0, 32'h0, 32'h0, 0);
        finish_txn(TMO, 32'h0F0F0F0F);
    endtask

    task automatic test_stale_mfc();
        Req      = 2'b01;
        Read_H_Write_L = 2'b11;
        Address0 = 32'h30;
        Data_In0 = 32'h31;
        RAM1_MFC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_27);
            n_cmp++;
            if (Grant !== 2'b00 || RAM1_Out_Enable !== 1'b0) begin
                n_bad++;
                $display("FAIL stale_mfc: got g=%b oe=%b, want 00 0",
                         Grant, RAM1_Out_Enable);
            end
        end
        RAM1_MFC = 1'b0;
        @(negedge clk_27);
        exp_idx   = 0;
        last_srv  = 0;
        exp_addr  = 32'h30;
        exp_wdata = 32'h31;
        exp_dir   = 1'b1;
        hold_req  = 0;
        n_cmp++;
        if (Grant !== 2'b01) begin
            n_bad++;
            $display("FAIL stale_release: got g=%b, want 01", Grant);
        end
        finish_txn(0, 32'h5A5A5A5A);
    endtask

    task automatic test_reset_mid();
        start_txn(2'b10, 2'b10, 32'h40, 32'h44, 32'h0, 32'h0, 0);
        RAM1_MFC = 1'b0;
        Req      = 2'b00;
        repeat (2) @(negedge clk_27);
        Reset = 1'b1;
        @(negedge clk_27);
        last_srv = 1;
        exp_dout = '0;
        n_cmp++;
        if (Grant !== 2'b00 || Done !== 2'b00 || RAM1_Out_Enable !== 1'b0 ||
            Data_Out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got g=%b d=%b oe=%b do=%h, want 00 00 0 0",
                     Grant, Done, RAM1_Out_Enable, Data_Out);
        end
        Reset = 1'b0;
        start_txn(2'b11, 2'b11, 32'h50, 32'h54, 32'h0, 32'h0, 0);
        n_cmp++;
        if (exp_idx != 0) begin
            n_bad++;
            $display("FAIL reset_mid_rr: model %0d, want 0", exp_idx);
        end
        finish_txn(3, 32'h13572468);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            start_txn(2'($urandom_range(1, 3)), 2'($urandom),
                      $urandom, $urandom, $urandom, $urandom,
                      bit'($urandom_range(0, 1)));
            finish_txn($urandom_range(0, TMO + 3), $urandom);
            Req = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_timeout();
        test_stale_mfc();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
